// File: rtl/ds_fetch_queue_pkg.sv
// Shared fetch/decode pipeline definitions: fs2ds bus layout and the
// decode-side queue payload.
package ds_fetch_queue_pkg;

  localparam int FS2DS_BUS_W = 64;
  localparam int INST_MSB    = 63;
  localparam int INST_LSB    = 32;
  localparam int PC_MSB      = 31;
  localparam int PC_LSB      = 0;
  localparam int DQ_BUS_W    = 65;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adef;
  } dq_entry_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/sync_fifo_flush.sv
// Generic DEPTH x WIDTH register FIFO with a synchronous clear.
// Occupancy is tracked by a counter so full and empty never alias.
module sync_fifo_flush #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 65,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = push && (count_r != CNT_FULL);
  assign pop_s  = pop  && (count_r != CNT_ZERO);

  // Pointer and occupancy bookkeeping; clear behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr_r  <= PTR_ZERO;
      rptr_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset && !clear) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rptr_r];
  assign count = count_r;

endmodule

// File: rtl/ds_fetch_queue.sv
// Decode-side fetch queue: buffers {inst, pc} from fetch, presents the head
// to the decoder, drops wrong-path entries on any flush, tags misaligned PCs.
module ds_fetch_queue
  import ds_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fs2ds_valid,
  input  logic [FS2DS_BUS_W-1:0] fs2ds_bus,
  output logic                   ds_allowin,
  input  logic                   br_taken,
  input  logic                   wb_ex,
  input  logic                   ertn_flush,
  output logic                   dq_valid,
  input  logic                   dq_ready,
  output logic [31:0]            dq_inst,
  output logic [31:0]            dq_pc,
  output logic                   dq_adef,
  output logic [PTR_W:0]         dq_count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ZERO = (PTR_W+1)'(0);

  logic          flush_s;
  logic          push_s;
  logic          pop_s;
  logic [PTR_W:0] count_s;
  dq_entry_t     wr_entry_s;
  dq_entry_t     rd_entry_s;

  assign flush_s = br_taken | wb_ex | ertn_flush;

  // allowin/valid come from the registered count only, never from ready or flush.
  assign ds_allowin = (count_s != CNT_FULL);
  assign dq_valid   = (count_s != CNT_ZERO);

  assign push_s = fs2ds_valid & ds_allowin & ~flush_s;
  assign pop_s  = dq_valid & dq_ready & ~flush_s;

  // Unpack the fetch bus and tag a misaligned fetch address.
  always_comb begin
    wr_entry_s.inst = fs2ds_bus[INST_MSB:INST_LSB];
    wr_entry_s.pc   = fs2ds_bus[PC_MSB:PC_LSB];
    wr_entry_s.adef = pc_misaligned(fs2ds_bus[PC_LSB+1:PC_LSB]);
  end

  sync_fifo_flush #(
    .DEPTH (DEPTH),
    .WIDTH (DQ_BUS_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_entry_s),
    .rdata (rd_entry_s),
    .count (count_s)
  );

  assign dq_inst  = rd_entry_s.inst;
  assign dq_pc    = rd_entry_s.pc;
  assign dq_adef  = rd_entry_s.adef;
  assign dq_count = count_s;

endmodule
